fwd_hazard_ctrl: RTL and testbench

Parametrised forwarding and hazard controller for the pipelined MIPS-32 core. It replaces the fixed two-source forwarding logic and resolves forwarding independently for every source operand. It also detects load-use hazards and sequences a multi-cycle multiply/divide unit occupying the EX stage. It sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers and drives the EX-stage operand muxes, the PC/IF/ID hold enables and the ID/EX bubble insertion, and it keeps a saturating stall-cycle counter.

---
 rtl/fwd_hazard_ctrl.sv | 95 +++++++++
 tb/tb_fwd_hazard_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: per-source EX forwarding, load-use detection, mul/div EX sequencing
// and a saturating stall-cycle counter for the pipelined MIPS-32 core.
module fwd_hazard_ctrl #(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int MD_LAT  = 4,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC*REG_AW-1:0] src_id_i,
   input  logic [NUM_SRC-1:0]        src_used_id_i,
   input  logic [NUM_SRC*REG_AW-1:0] src_ex_i,
   input  logic [REG_AW-1:0]         rd_ex_i,
   input  logic                      memread_ex_i,
   input  logic [REG_AW-1:0]         rd_mem_i,
   input  logic                      regwrite_mem_i,
   input  logic [REG_AW-1:0]         rd_wb_i,
   input  logic                      regwrite_wb_i,
   input  logic                      md_start_i,
   input  logic                      cnt_clr_i,
   output logic [2*NUM_SRC-1:0]      fwd_sel_o,
   output logic                      stall_fe_o,
   output logic                      bubble_ex_o,
   output logic                      md_hold_o,
   output logic                      md_done_o,
   output logic [CNT_W-1:0]          stall_cnt_o
);
   localparam int CW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic              lu;
   logic              hold, done;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
      logic [REG_AW-1:0] s;
      assign s = src_ex_i[g*REG_AW +: REG_AW];
      assign fwd_sel_o[2*g +: 2] =
         (regwrite_mem_i && rd_mem_i != '0 && rd_mem_i == s) ? 2'b10 :
         (regwrite_wb_i  && rd_wb_i  != '0 && rd_wb_i  == s) ? 2'b01 : 2'b00;
   end

   always_comb begin
      lu = 1'b0;
      for (int k = 0; k < NUM_SRC; k++)
         if (src_used_id_i[k] && src_id_i[k*REG_AW +: REG_AW] == rd_ex_i) lu = 1'b1;
      lu = lu && memread_ex_i && rd_ex_i != '0;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold    = 1'b0;
      done    = 1'b0;
      if (state_q == IDLE) begin
         if (md_start_i) begin
            hold    = 1'b1;
            state_d = BUSY;
            cnt_d   = CW'(MD_LAT - 2);
         end
      end else if (cnt_q != '0) begin
         hold  = 1'b1;
         cnt_d = cnt_q - 1'b1;
      end else begin
         done    = 1'b1;
         state_d = IDLE;
      end
   end

   // Gated by rst_n so an in-flight op is dropped the moment reset asserts.
   assign md_hold_o   = hold && rst_n;
   assign md_done_o   = done && rst_n;
   assign stall_fe_o  = lu || md_hold_o;
   assign bubble_ex_o = lu && !md_hold_o;
   assign stall_cnt_o = stall_cnt_q;

   assign stall_cnt_d = cnt_clr_i ? '0 :
                        (stall_fe_o && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed and randomized checks of fwd_hazard_ctrl against
// a cycle-position behavioural model kept in the bench.
module tb_fwd_hazard_ctrl;
   localparam int AW = 5, NS = 2, LAT = 4, CW = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk, rst_n;
   logic [NS*AW-1:0] src_id, src_ex;
   logic [NS-1:0] src_used_id;
   logic [AW-1:0] rd_ex, rd_mem, rd_wb;
   logic memread_ex, regwrite_mem, regwrite_wb, md_start, cnt_clr;
   logic [2*NS-1:0] fwd_sel;
   logic stall_fe, bubble_ex, md_hold, md_done;
   logic [CW-1:0] stall_cnt;

   int vectors = 0, miscompares = 0;
   int m_pos;
   int m_cnt;

   fwd_hazard_ctrl #(.REG_AW(AW), .NUM_SRC(NS), .MD_LAT(LAT), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .src_id_i(src_id), .src_used_id_i(src_used_id), .src_ex_i(src_ex),
      .rd_ex_i(rd_ex), .memread_ex_i(memread_ex),
      .rd_mem_i(rd_mem), .regwrite_mem_i(regwrite_mem),
      .rd_wb_i(rd_wb), .regwrite_wb_i(regwrite_wb),
      .md_start_i(md_start), .cnt_clr_i(cnt_clr),
      .fwd_sel_o(fwd_sel), .stall_fe_o(stall_fe), .bubble_ex_o(bubble_ex),
      .md_hold_o(md_hold), .md_done_o(md_done), .stall_cnt_o(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: position of the current mul/div op within its LAT-cycle EX occupancy (-1 idle).
   function automatic int cur_pos();
      return (m_pos < 0 && md_start) ? 0 : m_pos;
   endfunction

   function automatic logic [2*NS-1:0] exp_fwd();
      logic [2*NS-1:0] r;
      logic [AW-1:0] s;
      for (int k = 0; k < NS; k++) begin
         s = src_ex[k*AW +: AW];
         if (regwrite_mem && rd_mem != 0 && rd_mem == s) r[2*k +: 2] = 2'b10;
         else if (regwrite_wb && rd_wb != 0 && rd_wb == s) r[2*k +: 2] = 2'b01;
         else r[2*k +: 2] = 2'b00;
      end
      return r;
   endfunction

   function automatic logic exp_lu();
      logic hit = 1'b0;
      for (int k = 0; k < NS; k++)
         if (src_used_id[k] && src_id[k*AW +: AW] == rd_ex) hit = 1'b1;
      return memread_ex && rd_ex != 0 && hit;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pos <= -1;
         m_cnt <= 0;
      end else begin
         int c;
         logic st;
         c  = cur_pos();
         st = exp_lu() || (c >= 0 && c < LAT - 1);
         m_pos <= (c < 0 || c == LAT - 1) ? -1 : c + 1;
         m_cnt <= cnt_clr ? 0 : (st && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         int c;
         logic h, d, l;
         c = cur_pos();
         h = c >= 0 && c < LAT - 1;
         d = c == LAT - 1;
         l = exp_lu();
         chk("fwd_sel", 32'(fwd_sel), 32'(exp_fwd()));
         chk("stall_fe", 32'(stall_fe), 32'(l || h));
         chk("bubble_ex", 32'(bubble_ex), 32'(l && !h));
         chk("md_hold", 32'(md_hold), 32'(h));
         chk("md_done", 32'(md_done), 32'(d));
         chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet();
      src_id = '0; src_ex = '0; src_used_id = '0;
      rd_ex = '0; rd_mem = '0; rd_wb = '0;
      memread_ex = 0; regwrite_mem = 0; regwrite_wb = 0;
      md_start = 0; cnt_clr = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      quiet();
      repeat (2) step();
      chk("reset stall_cnt", 32'(stall_cnt), 0);
      chk("reset md_hold", 32'(md_hold), 0);
      chk("reset stall_fe", 32'(stall_fe), 0);
      rst_n = 1'b1;
      step();

      // forwarding priority and zero-register exclusion
      rd_mem = 5; rd_wb = 5; regwrite_mem = 1; regwrite_wb = 1; src_ex = {5'd5, 5'd5};
      #2 chk("fwd both mem", 32'(fwd_sel), 32'b1010);
      step(); regwrite_mem = 0;
      #2 chk("fwd both wb", 32'(fwd_sel), 32'b0101);
      step(); regwrite_mem = 1; rd_mem = 0; rd_wb = 0;
      #2 chk("fwd r0", 32'(fwd_sel), 32'b0000);
      step(); src_ex = {5'd7, 5'd3}; rd_mem = 3; rd_wb = 7;
      #2 chk("fwd indep", 32'(fwd_sel), 32'b0110);
      step(); quiet();

      // load-use for one cycle, then same regs but unused
      memread_ex = 1; rd_ex = 9; src_id = {5'd9, 5'd0}; src_used_id = 2'b10;
      #2 chk("lu stall", 32'(stall_fe), 1);
      chk("lu bubble", 32'(bubble_ex), 1);
      step(); memread_ex = 0;
      #2 chk("lu one cycle", 32'(stall_fe), 0);
      chk("lu cnt", 32'(stall_cnt), 1);
      step(); memread_ex = 1; src_used_id = 2'b00;
      #2 chk("lu unused", 32'(stall_fe), 0);
      step(); quiet();

      // mul/div back-to-back
      cnt_clr = 1; step(); cnt_clr = 0;
      md_start = 1;
      #2 chk("md c0 hold", 32'(md_hold), 1);
      for (int c = 1; c < LAT - 1; c++) begin
         step();
         #2 chk("md hold", 32'(md_hold), 1);
         chk("md no done", 32'(md_done), 0);
      end
      step();
      #2 chk("md done", 32'(md_done), 1);
      chk("md done hold", 32'(md_hold), 0);
      chk("md cnt", 32'(stall_cnt), LAT - 1);
      step();
      #2 chk("md b2b hold", 32'(md_hold), 1);
      md_start = 0;
      repeat (LAT) step();
      #2 chk("md idle", 32'(md_hold), 0);

      // reset mid-op
      md_start = 1; step();
      md_start = 0; rst_n = 0;
      #1 chk("rst md_hold", 32'(md_hold), 0);
      chk("rst md_done", 32'(md_done), 0);
      chk("rst cnt", 32'(stall_cnt), 0);
      repeat (2) step();
      rst_n = 1;
      step();
      #2 chk("post rst done", 32'(md_done), 0);

      // saturation and clear priority
      cnt_clr = 1; step(); cnt_clr = 0;
      memread_ex = 1; rd_ex = 4; src_id = {5'd0, 5'd4}; src_used_id = 2'b01;
      repeat (20) step();
      #2 chk("sat", 32'(stall_cnt), CMAX);
      cnt_clr = 1; step(); cnt_clr = 0;
      #2 chk("clr with stall", 32'(stall_cnt), 0);
      step(); quiet();

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         src_id = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         src_ex = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         src_used_id = 2'($urandom);
         rd_ex = 5'($urandom_range(0, 7));
         rd_mem = 5'($urandom_range(0, 7));
         rd_wb = 5'($urandom_range(0, 7));
         memread_ex = 1'($urandom);
         regwrite_mem = 1'($urandom);
         regwrite_wb = 1'($urandom);
         md_start = ($urandom_range(0, 3) == 0);
         cnt_clr = ($urandom_range(0, 49) == 0);
         step();
      end
      quiet();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
